// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: coin credit, priced selection, greedy change out.
// All outputs registered (1-cycle decision latency); coins during VEND/CHANGE are rejected.
module vend_ctrl_multi #(
  parameter int NUM_ITEMS  = 4,
  parameter int CREDIT_W   = 6,
  parameter int MAX_CREDIT = 40,
  parameter int SEL_W      = $clog2(NUM_ITEMS)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [2:0]                    coin,
  input  logic [NUM_ITEMS*CREDIT_W-1:0] price,
  input  logic [NUM_ITEMS-1:0]          stock_empty,
  input  logic [SEL_W-1:0]              select,
  input  logic                          select_valid,
  input  logic                          cancel,
  output logic                          vend,
  output logic [SEL_W-1:0]              vend_item,
  output logic [2:0]                    change,
  output logic [CREDIT_W-1:0]           credit,
  output logic [1:0]                    state,
  output logic                          coin_reject,
  output logic                          sel_error
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_VEND    = 2'd2;
  localparam logic [1:0] S_CHANGE  = 2'd3;

  localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W+1)'(MAX_CREDIT);

  // Coin codes 1..5 are numerically equal to their value in nickel units.
  function automatic logic [2:0] pick_coin(input logic [CREDIT_W-1:0] c);
    if (c >= CREDIT_W'(5))      return 3'd5;
    else if (c >= CREDIT_W'(2)) return 3'd2;
    else if (c != '0)           return 3'd1;
    else                        return 3'd0;
  endfunction

  logic [1:0]          state_n;
  logic [CREDIT_W-1:0] credit_n;
  logic                vend_n;
  logic [SEL_W-1:0]    item_n;
  logic [2:0]          change_n;
  logic                reject_n;
  logic                selerr_n;

  logic                coin_ok;
  logic                coin_seen;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_empty;
  logic                sel_hit;
  logic [2:0]          give;
  logic [CREDIT_W-1:0] credit_left;

  always_comb begin
    coin_seen   = (coin != 3'd0);
    coin_ok     = coin_seen && (coin <= 3'd5);
    sum         = {1'b0, credit} + (CREDIT_W+1)'(coin);
    give        = pick_coin(credit);
    credit_left = credit - CREDIT_W'(give);

    sel_price = '0;
    sel_empty = 1'b1;
    sel_hit   = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (select == SEL_W'(i)) begin
        sel_hit   = 1'b1;
        sel_price = price[i*CREDIT_W +: CREDIT_W];
        sel_empty = stock_empty[i];
      end
    end

    state_n  = state;
    credit_n = credit;
    vend_n   = 1'b0;
    item_n   = vend_item;
    change_n = 3'd0;
    reject_n = 1'b0;
    selerr_n = 1'b0;

    case (state)
      S_IDLE, S_COLLECT: begin
        if (cancel) begin
          reject_n = coin_seen;
          if (credit != '0) begin
            state_n  = S_CHANGE;
            change_n = give;
            credit_n = credit_left;
          end
        end else if (select_valid) begin
          reject_n = coin_seen;
          if (!sel_hit || sel_empty || (credit < sel_price)) begin
            selerr_n = 1'b1;
          end else begin
            credit_n = credit - sel_price;
            item_n   = select;
            vend_n   = 1'b1;
            state_n  = S_VEND;
          end
        end else if (coin_seen) begin
          if (coin_ok && (sum <= MAX_C)) begin
            credit_n = sum[CREDIT_W-1:0];
            state_n  = S_COLLECT;
          end else begin
            reject_n = 1'b1;
          end
        end
      end
      default: begin
        // VEND and CHANGE both pay out remaining credit; the first coin leaves on the VEND exit edge.
        reject_n = coin_seen;
        if (credit != '0) begin
          state_n  = S_CHANGE;
          change_n = give;
          credit_n = credit_left;
        end else begin
          state_n = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= S_IDLE;
      credit      <= '0;
      vend        <= 1'b0;
      vend_item   <= '0;
      change      <= 3'd0;
      coin_reject <= 1'b0;
      sel_error   <= 1'b0;
    end else begin
      state       <= state_n;
      credit      <= credit_n;
      vend        <= vend_n;
      vend_item   <= item_n;
      change      <= change_n;
      coin_reject <= reject_n;
      sel_error   <= selerr_n;
    end
  end

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Bench for vend_ctrl_multi: directed vectors, a credit/coin-queue model checked every cycle, plus literal spot checks.
module tb_vend_ctrl_multi;

  localparam int NI = 4;
  localparam int CW = 6;
  localparam int MAXC = 40;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    coin = 3'd0;
  logic [NI*CW-1:0] price;
  logic [NI-1:0] stock_empty;
  logic [1:0]    select = 2'd0;
  logic          select_valid = 1'b0;
  logic          cancel = 1'b0;
  logic          vend;
  logic [1:0]    vend_item;
  logic [2:0]    change;
  logic [CW-1:0] credit;
  logic [1:0]    state;
  logic          coin_reject;
  logic          sel_error;

  vend_ctrl_multi #(.NUM_ITEMS(NI), .CREDIT_W(CW), .MAX_CREDIT(MAXC)) dut (
    .clock(clock), .reset(reset), .coin(coin), .price(price),
    .stock_empty(stock_empty), .select(select), .select_valid(select_valid),
    .cancel(cancel), .vend(vend), .vend_item(vend_item), .change(change),
    .credit(credit), .state(state), .coin_reject(coin_reject), .sel_error(sel_error)
  );

  always #5 clock = ~clock;

  // Price list in nickel units; item 2 is sold out, item 3 is free.
  int prices [NI] = '{5, 5, 2, 0};

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Expected outputs after the most recent edge.
  int m_state, m_credit, m_vend, m_item, m_change, m_rej, m_serr;
  int coins_q [$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Change for credit c: quarters, then dimes, then a nickel for any odd remainder.
  task automatic start_payout();
    int c;
    c = m_credit;
    coins_q.delete();
    for (int k = 0; k < c / 5; k++) coins_q.push_back(5);
    for (int k = 0; k < (c % 5) / 2; k++) coins_q.push_back(2);
    if ((c % 5) % 2 != 0) coins_q.push_back(1);
    m_state  = 3;
    m_change = coins_q.pop_front();
    m_credit = m_credit - m_change;
  endtask

  task automatic model_step();
    int ci, si;
    ci = int'(coin);
    si = int'(select);
    m_vend = 0; m_change = 0; m_rej = 0; m_serr = 0;
    if (!reset) begin
      m_state = 0; m_credit = 0; m_item = 0;
      coins_q.delete();
      return;
    end
    if (m_state <= 1) begin
      if (cancel) begin
        m_rej = (ci != 0);
        if (m_credit > 0) start_payout();
      end else if (select_valid) begin
        m_rej = (ci != 0);
        if (si >= NI || stock_empty[si] || m_credit < prices[si]) m_serr = 1;
        else begin
          m_credit = m_credit - prices[si];
          m_item = si; m_vend = 1; m_state = 2;
        end
      end else if (ci != 0) begin
        if (ci <= 5 && m_credit + ci <= MAXC) begin
          m_credit = m_credit + ci; m_state = 1;
        end else m_rej = 1;
      end
    end else if (m_state == 2) begin
      m_rej = (ci != 0);
      if (m_credit > 0) start_payout();
      else m_state = 0;
    end else begin
      m_rej = (ci != 0);
      if (coins_q.size() > 0) begin
        m_change = coins_q.pop_front();
        m_credit = m_credit - m_change;
      end else m_state = 0;
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("state", int'(state), m_state);
      chk("credit", int'(credit), m_credit);
      chk("vend", int'(vend), m_vend);
      if (m_vend != 0) chk("vend_item", int'(vend_item), m_item);
      chk("change", int'(change), m_change);
      chk("coin_reject", int'(coin_reject), m_rej);
      chk("sel_error", int'(sel_error), m_serr);
    end
  end

  task automatic drive(input logic [2:0] c, input logic [1:0] s, input logic sv,
                       input logic cn, input logic r);
    coin = c; select = s; select_valid = sv; cancel = cn; reset = r;
    @(posedge clock);
    model_step();
    chk_en = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(3'd0, 2'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic put(input logic [2:0] c);
    drive(c, 2'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic sel(input logic [1:0] s, input logic [2:0] c);
    drive(c, s, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic do_cancel(input logic [2:0] c);
    drive(c, 2'd0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    price       = {6'd0, 6'd2, 6'd5, 6'd5};
    stock_empty = 4'b0100;

    drive(3'd5, 2'd1, 1'b1, 1'b1, 1'b0);
    drive(3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("rst.state", int'(state), 0);
    chk("rst.credit", int'(credit), 0);
    chk("rst.change", int'(change), 0);
    idle(1);

    // Exact-price purchase.
    put(3'd5);
    chk("A.credit", int'(credit), 5);
    sel(2'd0, 3'd0);
    chk("A.vend", int'(vend), 1);
    chk("A.credit0", int'(credit), 0);
    idle(1);
    chk("A.idle", int'(state), 0);

    // Purchase with change 2 then 1.
    put(3'd1); put(3'd2); put(3'd5);
    chk("B.credit", int'(credit), 8);
    sel(2'd1, 3'd0);
    chk("B.item", int'(vend_item), 1);
    idle(1);
    chk("B.chg1", int'(change), 2);
    idle(1);
    chk("B.chg2", int'(change), 1);
    idle(1);
    chk("B.done", int'(state), 0);

    // Credit ceiling and invalid coin codes.
    for (int k = 0; k < 7; k++) put(3'd5);
    put(3'd3);
    chk("C.credit38", int'(credit), 38);
    put(3'd5);
    chk("C.rej", int'(coin_reject), 1);
    put(3'd1);
    chk("C.credit39", int'(credit), 39);
    put(3'd6);
    chk("C.rej6", int'(coin_reject), 1);
    put(3'd7);
    put(3'd2);
    put(3'd1);
    chk("C.credit40", int'(credit), 40);
    do_cancel(3'd0);
    idle(10);

    // Selection errors, coin/select collision, free item with leftover credit.
    put(3'd2); put(3'd1);
    sel(2'd0, 3'd0);
    chk("D.serr", int'(sel_error), 1);
    chk("D.credit", int'(credit), 3);
    sel(2'd2, 3'd0);
    chk("D.soldout", int'(sel_error), 1);
    sel(2'd1, 3'd2);
    chk("D.collide_rej", int'(coin_reject), 1);
    sel(2'd3, 3'd2);
    chk("D.free_vend", int'(vend), 1);
    idle(4);
    sel(2'd3, 3'd0);
    chk("D.free0", int'(vend), 1);
    idle(1);
    do_cancel(3'd1);
    chk("D.cancel0_rej", int'(coin_reject), 1);
    idle(1);

    // Cancel payout of 13 with a coin arriving mid-payout.
    put(3'd5); put(3'd5); put(3'd3);
    do_cancel(3'd0);
    chk("E.chg1", int'(change), 5);
    put(3'd5);
    chk("E.rej", int'(coin_reject), 1);
    chk("E.credit", int'(credit), 3);
    idle(1);
    chk("E.chg3", int'(change), 2);
    idle(2);
    chk("E.idle", int'(state), 0);

    // Reset during payout discards remaining credit.
    put(3'd5); put(3'd5); put(3'd2);
    do_cancel(3'd0);
    idle(1);
    chk("F.chg2", int'(change), 5);
    drive(3'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("F.state", int'(state), 0);
    chk("F.credit", int'(credit), 0);
    chk("F.change", int'(change), 0);
    idle(1);
    put(3'd5);
    chk("F.credit5", int'(credit), 5);
    do_cancel(3'd0);
    idle(3);

    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
